// File: rtl/uv_exposure_sequencer.sv
// uv_exposure_sequencer: timed ON/OFF UV exposure runs, issuing digipot intensity writes over the shared i2c write channel
module uv_exposure_sequencer #(
  parameter int CLK_HZ = 16_000_000,
  parameter int TICKS_PER_MS = CLK_HZ / 1000,
  parameter int MAX_TIME_MS = 9999,
  parameter int MAX_INTENSITY = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        fire,
  input  logic        abort,
  input  logic [13:0] on_time_ms,
  input  logic [13:0] off_time_ms,
  input  logic [13:0] repetitions,
  input  logic [7:0]  intensity,
  input  logic        i2c_ready,
  output logic        i2c_enable,
  output logic [7:0]  i2c_data,
  output logic [2:0]  state,
  output logic        emitter_on,
  output logic [13:0] elapsed_ms,
  output logic [13:0] rep_count,
  output logic        done
);
  localparam int TW = TICKS_PER_MS > 1 ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_MS - 1);
  localparam logic [13:0] MAX_T = 14'(MAX_TIME_MS);
  localparam logic [7:0] MAX_I = 8'(MAX_INTENSITY);
  typedef enum logic [2:0] {IDLE, ARMED, WR_ON, ON, WR_OFF, OFF, SAFE} state_t;
  state_t cur, nxt;
  logic [1:0] ph, ph_n, hs_ph;
  logic pend, pend_n, done_n, wr, hs_done, timed, wrap, phase_end;
  logic [TW-1:0] tick, tick_n;
  logic [13:0] el_n, rep_n, rep_inc, ptime, lon, loff, lreps, lon_n, loff_n, lreps_n;
  logic [7:0] lvl, lvl_n;
  assign state = cur;
  assign emitter_on = cur == ON;
  assign wr = cur == WR_ON || cur == WR_OFF || cur == SAFE;
  assign i2c_enable = wr && ph == 2'd0 && i2c_ready;
  assign i2c_data = (i2c_enable && cur == WR_ON) ? lvl : 8'd0;
  // write handshake: 0 = waiting to issue, 1 = ignore ready once, 2 = waiting for completion
  assign hs_ph = ph == 2'd0 ? {1'b0, i2c_ready} : ph == 2'd1 ? 2'd2 : (i2c_ready ? 2'd0 : 2'd2);
  assign hs_done = wr && ph == 2'd2 && i2c_ready;
  assign timed = cur == ON || cur == OFF;
  assign ptime = cur == ON ? lon : loff;
  assign wrap = tick == TICK_LAST;
  assign phase_end = timed && (elapsed_ms == ptime || (wrap && elapsed_ms + 14'd1 == ptime));
  assign rep_inc = rep_count + 14'd1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cur <= IDLE;
      ph <= 2'd0;
      pend <= 1'b0;
      tick <= '0;
      elapsed_ms <= 14'd0;
      rep_count <= 14'd0;
      lon <= 14'd0;
      loff <= 14'd0;
      lreps <= 14'd0;
      lvl <= 8'd0;
      done <= 1'b0;
    end else begin
      cur <= nxt;
      ph <= ph_n;
      pend <= pend_n;
      tick <= tick_n;
      elapsed_ms <= el_n;
      rep_count <= rep_n;
      lon <= lon_n;
      loff <= loff_n;
      lreps <= lreps_n;
      lvl <= lvl_n;
      done <= done_n;
    end
  always_comb begin
    nxt = cur;
    ph_n = wr ? hs_ph : 2'd0;
    pend_n = pend;
    tick_n = (timed && elapsed_ms != ptime) ? (wrap ? '0 : tick + 1'b1) : tick;
    el_n = (timed && elapsed_ms != ptime && wrap) ? elapsed_ms + 14'd1 : elapsed_ms;
    if (hs_done) begin
      tick_n = '0;
      el_n = 14'd0;
    end
    rep_n = rep_count;
    lon_n = lon;
    loff_n = loff;
    lreps_n = lreps;
    lvl_n = lvl;
    done_n = 1'b0;
    if (cur == IDLE) nxt = arm ? ARMED : IDLE;
    else if (cur == SAFE) begin
      // a write caught in flight finishes first, then the zero write goes out
      if (hs_done) begin
        pend_n = 1'b0;
        if (!pend) nxt = arm ? ARMED : IDLE;
      end
    end else if (abort || !arm) begin
      nxt = SAFE;
      pend_n = wr && hs_ph != 2'd0;
    end else if (cur == ARMED) begin
      if (fire) begin
        nxt = WR_ON;
        lon_n = on_time_ms > MAX_T ? MAX_T : on_time_ms;
        loff_n = off_time_ms > MAX_T ? MAX_T : off_time_ms;
        lreps_n = repetitions == 14'd0 ? 14'd1 : (repetitions > MAX_T ? MAX_T : repetitions);
        lvl_n = intensity > MAX_I ? MAX_I : intensity;
        rep_n = 14'd0;
      end
    end else if (cur == WR_ON) nxt = hs_done ? ON : WR_ON;
    else if (cur == WR_OFF) nxt = hs_done ? OFF : WR_OFF;
    else if (cur == ON) nxt = phase_end ? WR_OFF : ON;
    else if (cur == OFF && phase_end) begin
      rep_n = rep_inc;
      nxt = rep_inc < lreps ? WR_ON : ARMED;
      done_n = rep_inc >= lreps;
    end
  end
endmodule

// File: doc/uv_exposure_sequencer.md
Name: uv_exposure_sequencer

Overview:
Sequences a UV exposure run: a number of ON/OFF cycles with millisecond timing. During ON it sets the emitter intensity by writing to the digipot through the shared i2c_controller write channel, and during OFF it writes zero. It sits between the front-panel control FSM (arm/fire/abort, parameter registers) and i2c_controller, and is the only issuer of intensity writes. It also exports its phase, elapsed time and repetition count for the seven-segment display path.

Parameters:
CLK_HZ, 16_000_000, system clock frequency.
TICKS_PER_MS, CLK_HZ/1000, clock cycles per millisecond tick.
MAX_TIME_MS, 9999, clamp for on/off times and repetitions.
MAX_INTENSITY, 100, clamp for the intensity byte.

Ports:
clk  in  1  system clock.
rst  in  1  reset, asynchronous, active-high.
arm  in  1  level; 1 = armed (key switch), 0 = disarmed.
fire  in  1  single-cycle start pulse.
abort  in  1  single-cycle abort pulse.
on_time_ms  in  14  ON duration per repetition, in ms.
off_time_ms  in  14  OFF duration per repetition, in ms.
repetitions  in  14  number of ON/OFF cycles.
intensity  in  8  digipot code used during ON.
i2c_ready  in  1  i2c_controller idle, can accept a command.
i2c_enable  out  1  single-cycle write request.
i2c_data  out  8  write byte, valid while i2c_enable=1.
state  out  3  current FSM state encoding.
emitter_on  out  1  high in ON only.
elapsed_ms  out  14  ms elapsed in the current ON/OFF phase.
rep_count  out  14  completed repetitions.
done  out  1  single-cycle pulse when a run completes normally.

Behaviour:
- Reset: all outputs 0, state=IDLE, tick counter=0, latched parameters=0.
- States: IDLE=0, ARMED=1, WR_ON=2, ON=3, WR_OFF=4, OFF=5, SAFE=6.
- IDLE -> ARMED when arm=1. From any state other than IDLE and SAFE, arm=0 -> SAFE.
- ARMED + fire -> WR_ON. On this transition the block latches the parameters with these clamps:
  - times and repetitions are clamped to MAX_TIME_MS;
  - intensity is clamped to MAX_INTENSITY;
  - repetitions=0 is treated as 1.
  - rep_count is cleared to 0.
- fire outside ARMED is ignored.
- Write handshake (WR_ON, WR_OFF, SAFE):
  - i2c_enable pulses for 1 cycle in the first cycle where i2c_ready=1.
  - i2c_data = latched intensity (WR_ON) or 0 (WR_OFF, SAFE).
  - i2c_ready is then ignored for 1 cycle, and the write counts as complete on the next cycle with i2c_ready=1.
  - i2c_enable never asserts while i2c_ready=0, and never more than once per write.
- WR_ON complete -> ON. elapsed_ms=0, tick counter=0, emitter_on=1 from the next cycle.
- ON / OFF timing:
  - The tick counter counts 0..TICKS_PER_MS-1. At wrap, elapsed_ms increments.
  - When elapsed_ms reaches the latched phase time, ON -> WR_OFF and OFF -> (repeat check).
  - A phase time of 0 exits on the first cycle in that state, with no tick counted.
- WR_OFF complete -> OFF. elapsed_ms and the tick counter are cleared.
- OFF end: rep_count increments.
  - If rep_count+1 < latched repetitions -> WR_ON.
  - Otherwise -> ARMED with done=1 for 1 cycle. rep_count holds its final value.
- abort in any non-IDLE state -> SAFE (ARMED included). An in-flight i2c_enable is not retracted.
- SAFE:
  - If entered with a write already issued, it waits for that write to complete, then issues the 0 write.
  - After the 0 write it goes to IDLE if arm=0, else to ARMED.
  - abort and arm=0 during SAFE are ignored.
  - done is never asserted on the abort path.
- Simultaneous events: abort beats arm=0, arm=0 beats fire, and fire beats arm.
- Parameter inputs changing mid-run have no effect until the next fire.
- emitter_on is 0 in every state except ON.

Test Plan:
- Normal run: arm=1, on=3, off=2, reps=2, intensity=50, TICKS_PER_MS=4, ready always 1 -> writes are 50,0,50,0. ON lasts 12 cycles and OFF lasts 8. done pulses once, rep_count=2, state=ARMED.
- Clamping: intensity=200, reps=0, on=16383 -> i2c_data=100 at WR_ON, latched on=9999, exactly 1 repetition.
- Busy resource: hold i2c_ready=0 for 20 cycles after fire -> i2c_enable stays 0, then pulses exactly once when ready rises. ON starts only after the write completes.
- Abort mid-ON at elapsed_ms=1 -> emitter_on drops the next cycle, a single write of 0 follows, then state=ARMED and done never asserts.
- Disarm during WR_ON with a write in flight -> the block waits for ready, writes 0, then goes to IDLE. A fire pulse in IDLE is ignored.
- Zero times: on=0, off=0, reps=3 -> six writes alternating intensity and 0, rep_count=3, done pulses once.
- Async reset asserted mid-OFF -> all outputs are 0 immediately, with no clock edge needed.
